// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, owner
// encoding of the read-response path and a small alignment helper.
package dmem_arb_pkg;

  localparam int DEF_AW           = 32;
  localparam int DEF_DW           = 32;
  localparam int DEF_MEM_AW       = 10;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int STREAK_W         = 4;
  localparam int STAT_W           = 32;

  // Owner of the read response that completes in the next cycle.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

  typedef enum logic [1:0] {
    RSP_NONE = OWN_NONE,
    RSP_CPU  = OWN_CPU,
    RSP_DMA  = OWN_DMA
  } rsp_state_e;

  // Word accesses only: both low address bits must be zero.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arb_sat_cnt.sv
// Saturating event counter used by the optional arbiter statistics
// (present only when DMEM_ARB_STATS_EN is defined in the top).
module dmem_arb_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  // Count up on each event, stopping at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (inc && !(&count_reg)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has fixed priority, a streak counter forces a DMA
// grant after STARVE_LIMIT consecutive contested CPU wins. Read data returns
// to the winner one cycle after the grant. Misaligned accesses are issued
// with the write suppressed and are flagged by an err pulse.
// Optional statistics counters: define DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int MEM_AW       = DEF_MEM_AW,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_err,
  // DMA port
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [AW-1:0]     dma_addr,
  input  logic [DW-1:0]     dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DW-1:0]     dma_rdata,
  output logic              dma_err,
  // Memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_cpu_gnt,
  output logic [STAT_W-1:0] stat_dma_gnt,
  output logic [STAT_W-1:0] stat_conflict
`endif
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  logic [STREAK_W-1:0] streak_reg, streak_next;
  rsp_state_e          state_reg, state_next;
  logic                mis_reg, mis_next;
  logic                cpu_err_reg, cpu_err_next;
  logic                dma_err_reg, dma_err_next;
  logic [DW-1:0]       cpu_hold_reg, dma_hold_reg;

  logic                both_req;
  logic                dma_wins;
  logic                any_gnt;
  logic                win_we;
  logic [AW-1:0]       win_addr;
  logic [DW-1:0]       win_wdata;
  logic                aligned;
  logic                unused_addr_bits;

  // Grant selection and memory drive; the DMA wins a contest only once the
  // CPU streak has reached the starvation limit.
  always_comb begin
    both_req  = cpu_req & dma_req;
    dma_wins  = dma_req & (~cpu_req | (streak_reg == LIMIT));
    cpu_gnt   = cpu_req & ~dma_wins;
    dma_gnt   = dma_wins;
    any_gnt   = cpu_gnt | dma_gnt;

    win_we    = dma_gnt ? dma_we    : cpu_we;
    win_addr  = dma_gnt ? dma_addr  : cpu_addr;
    win_wdata = dma_gnt ? dma_wdata : cpu_wdata;
    aligned   = is_aligned(win_addr[1:0]);

    mem_en    = any_gnt;
    mem_we    = any_gnt & win_we & aligned;
    mem_addr  = win_addr[MEM_AW+1:2];
    mem_wdata = win_wdata;
  end

  // Upper byte-address bits lie outside the memory and are ignored.
  assign unused_addr_bits = ^win_addr[AW-1:MEM_AW+2];

  // Streak: counts contested CPU wins, cleared whenever DMA wins or is idle.
  always_comb begin
    streak_next = '0;
    if (both_req && cpu_gnt) begin
      streak_next = streak_reg + STREAK_W'(1);
    end
  end

  // State registers: streak, response owner, misaligned flag and err pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_reg  <= '0;
      state_reg   <= RSP_NONE;
      mis_reg     <= 1'b0;
      cpu_err_reg <= 1'b0;
      dma_err_reg <= 1'b0;
    end else begin
      streak_reg  <= streak_next;
      state_reg   <= state_next;
      mis_reg     <= mis_next;
      cpu_err_reg <= cpu_err_next;
      dma_err_reg <= dma_err_next;
    end
  end

  // Response FSM: pick the owner of next cycle's read data, and route the
  // memory read data (forced to zero for a misaligned read) to that owner.
  always_comb begin
    state_next   = RSP_NONE;
    mis_next     = 1'b0;
    cpu_err_next = 1'b0;
    dma_err_next = 1'b0;
    cpu_rvalid   = 1'b0;
    dma_rvalid   = 1'b0;
    cpu_rdata    = cpu_hold_reg;
    dma_rdata    = dma_hold_reg;

    if (any_gnt && !win_we) begin
      state_next = dma_gnt ? RSP_DMA : RSP_CPU;
    end
    mis_next     = any_gnt & ~aligned;
    cpu_err_next = cpu_gnt & ~aligned;
    dma_err_next = dma_gnt & ~aligned;

    case (state_reg)
      RSP_CPU: begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = mis_reg ? '0 : mem_rdata;
      end
      RSP_DMA: begin
        dma_rvalid = 1'b1;
        dma_rdata  = mis_reg ? '0 : mem_rdata;
      end
      default: ;
    endcase
  end

  // Keep the last delivered read word on each port while rvalid is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_hold_reg <= '0;
      dma_hold_reg <= '0;
    end else begin
      if (cpu_rvalid) cpu_hold_reg <= cpu_rdata;
      if (dma_rvalid) dma_hold_reg <= dma_rdata;
    end
  end

  assign cpu_err = cpu_err_reg;
  assign dma_err = dma_err_reg;

`ifdef DMEM_ARB_STATS_EN
  logic [2:0]        stat_inc;
  logic [STAT_W-1:0] stat_val [3];

  assign stat_inc = {both_req, dma_gnt, cpu_gnt};

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_stat
    dmem_arb_sat_cnt #(.W(STAT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stat_inc[gi]),
      .count (stat_val[gi])
    );
  end

  assign stat_cpu_gnt  = stat_val[0];
  assign stat_dma_gnt  = stat_val[1];
  assign stat_conflict = stat_val[2];
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model with a shadow memory.
module tb_dmem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int MEM_AW = 12;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0]     cpu_addr = '0;
  logic [DW-1:0]     cpu_wdata = '0;
  logic              cpu_gnt, cpu_rvalid, cpu_err;
  logic [DW-1:0]     cpu_rdata;
  logic              dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0]     dma_addr = '0;
  logic [DW-1:0]     dma_wdata = '0;
  logic              dma_gnt, dma_rvalid, dma_err;
  logic [DW-1:0]     dma_rdata;
  logic              mem_en, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0]       stat_cpu_gnt, stat_dma_gnt, stat_conflict;
`endif

  int vectors = 0;
  int miscompares = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_AW(MEM_AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_cpu_gnt(stat_cpu_gnt), .stat_dma_gnt(stat_dma_gnt), .stat_conflict(stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory behind the arbiter.
  logic [DW-1:0] mem_arr [1<<MEM_AW];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem_arr[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem_arr[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [DW-1:0] model_mem [1<<MEM_AW];
  int            m_streak = 0;
  bit            pc_rd = 0, pc_err = 0, pd_rd = 0, pd_err = 0;
  logic [DW-1:0] pc_data = '0, pd_data = '0, hold_c = '0, hold_d = '0;

  // Every cycle: check the registered responses promised last cycle, then
  // decide this cycle's winner from the priority/starvation rule.
  always @(negedge clk) begin
    bit w_cpu, w_dma, we, al;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int word;
    if (!rst) begin
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
      chk("rst_dma_rvalid", 32'(dma_rvalid), 0);
      chk("rst_cpu_err", 32'(cpu_err), 0);
      chk("rst_dma_err", 32'(dma_err), 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dma_rdata", dma_rdata, 0);
      m_streak = 0; pc_rd = 0; pc_err = 0; pd_rd = 0; pd_err = 0;
      hold_c = '0; hold_d = '0;
    end else begin
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(pc_rd));
      chk("dma_rvalid", 32'(dma_rvalid), 32'(pd_rd));
      chk("cpu_err", 32'(cpu_err), 32'(pc_err));
      chk("dma_err", 32'(dma_err), 32'(pd_err));
      chk("cpu_rdata", cpu_rdata, pc_rd ? pc_data : hold_c);
      chk("dma_rdata", dma_rdata, pd_rd ? pd_data : hold_d);
      if (pc_rd) hold_c = pc_data;
      if (pd_rd) hold_d = pd_data;

      w_cpu = cpu_req && !(dma_req && m_streak == LIMIT);
      w_dma = dma_req && !w_cpu;
      chk("cpu_gnt", 32'(cpu_gnt), 32'(w_cpu));
      chk("dma_gnt", 32'(dma_gnt), 32'(w_dma));
      chk("mem_en", 32'(mem_en), 32'(w_cpu || w_dma));

      pc_rd = 0; pc_err = 0; pd_rd = 0; pd_err = 0;
      if (w_cpu || w_dma) begin
        we   = w_cpu ? cpu_we : dma_we;
        addr = w_cpu ? cpu_addr : dma_addr;
        wd   = w_cpu ? cpu_wdata : dma_wdata;
        al   = (addr % 4) == 0;
        word = int'((addr / 4) % (1 << MEM_AW));
        chk("mem_addr", 32'(mem_addr), 32'(word));
        chk("mem_we", 32'(mem_we), 32'(we && al));
        chk("mem_wdata", mem_wdata, wd);
        if (w_cpu) begin
          pc_rd = !we; pc_err = !al; pc_data = al ? model_mem[word] : '0;
        end else begin
          pd_rd = !we; pd_err = !al; pd_data = al ? model_mem[word] : '0;
        end
        if (we && al) model_mem[word] = wd;
      end
      m_streak = (cpu_req && dma_req && w_cpu) ? m_streak + 1 : 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    logic [9:0] pat;
    bit cg, dg;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] s_c, s_d, s_x;
`endif
    for (int i = 0; i < (1 << MEM_AW); i++) begin
      mem_arr[i] = '0;
      model_mem[i] = '0;
    end
    mem_arr[12'h400] = 32'd5;
    model_mem[12'h400] = 32'd5;

    step(); step(); step();
    rst = 1'b1;

    // CPU read of preloaded word
    step();
    set_cpu(1, 0, 32'h1000, 0); #1;
    $display("txn cpu_rd 0x1000");
    chk("t1_cpu_gnt", 32'(cpu_gnt), 1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h400);
    step();
    set_cpu(0, 0, 0, 0); #1;
    chk("t1_cpu_rvalid", 32'(cpu_rvalid), 1);
    chk("t1_cpu_rdata", cpu_rdata, 32'd5);
    step(); #1;
    chk("t1_rdata_hold", cpu_rdata, 32'd5);
    chk("t1_rvalid_low", 32'(cpu_rvalid), 0);

    // Continuous contention: C,C,C,C,D repeating
`ifdef DMEM_ARB_STATS_EN
    s_c = stat_cpu_gnt; s_d = stat_dma_gnt; s_x = stat_conflict;
`endif
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      set_cpu(1, 0, 32'h1000 + 32'(4 * i), 0);
      set_dma(1, 0, 32'h1008, 0); #1;
      pat = {pat[8:0], cpu_gnt};
      $display("txn contest %0d cpu_gnt=%0b dma_gnt=%0b", i, cpu_gnt, dma_gnt);
    end
    chk("t2_grant_pattern", 32'(pat), 32'b1111011110);
    step();
    set_cpu(0, 0, 0, 0); set_dma(0, 0, 0, 0); #1;
`ifdef DMEM_ARB_STATS_EN
    chk("t2_stat_cpu", stat_cpu_gnt - s_c, 8);
    chk("t2_stat_dma", stat_dma_gnt - s_d, 2);
    chk("t2_stat_conflict", stat_conflict - s_x, 10);
`endif

    // CPU write then DMA read of the same word
    step();
    set_cpu(1, 1, 32'h1004, 32'hAB); #1;
    $display("txn cpu_wr 0x1004=0xAB");
    chk("t3_mem_we", 32'(mem_we), 1);
    step();
    set_cpu(0, 0, 0, 0);
    set_dma(1, 0, 32'h1004, 0); #1;
    $display("txn dma_rd 0x1004");
    chk("t3_dma_gnt", 32'(dma_gnt), 1);
    step();
    set_dma(0, 0, 0, 0); #1;
    chk("t3_dma_rvalid", 32'(dma_rvalid), 1);
    chk("t3_dma_rdata", dma_rdata, 32'hAB);
    chk("t3_cpu_rvalid", 32'(cpu_rvalid), 0);

    // Misaligned DMA write
    step();
    set_dma(1, 1, 32'h1006, 32'hFF); #1;
    $display("txn dma_wr misaligned 0x1006");
    chk("t4_mem_en", 32'(mem_en), 1);
    chk("t4_mem_we", 32'(mem_we), 0);
    step();
    set_dma(0, 0, 0, 0); #1;
    chk("t4_dma_err", 32'(dma_err), 1);
    chk("t4_dma_rvalid", 32'(dma_rvalid), 0);
    step(); #1;
    chk("t4_dma_err_gone", 32'(dma_err), 0);
    chk("t4_mem_kept", mem_arr[12'h401], 32'hAB);

    // Reset between grant and response
    step();
    set_cpu(1, 0, 32'h1000, 0); #1;
    $display("txn cpu_rd 0x1000 then reset");
    chk("t5_cpu_gnt", 32'(cpu_gnt), 1);
    @(negedge clk); #1;
    rst = 1'b0;
    set_cpu(0, 0, 0, 0);
    step();
    chk("t5_no_rvalid", 32'(cpu_rvalid), 0);
    step();
    rst = 1'b1;
    step();
    chk("t5_no_rvalid_after", 32'(cpu_rvalid), 0);
    set_cpu(1, 0, 32'h1004, 0); #1;
    chk("t5_regrant", 32'(cpu_gnt), 1);
    step();
    set_cpu(0, 0, 0, 0); #1;
    chk("t5_rvalid", 32'(cpu_rvalid), 1);
    chk("t5_rdata", cpu_rdata, 32'hAB);

    // Randomized traffic; a requester mostly holds until granted
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cg = cpu_gnt; dg = dma_gnt;
      @(posedge clk); #1;
      if (!(cpu_req && !cg && $urandom_range(9) != 0))
        set_cpu($urandom_range(99) < 60, $urandom_range(1),
                32'h1000 + ($urandom_range(15) << 2) + (($urandom_range(7) == 0) ? $urandom_range(3, 1) : 0),
                $urandom);
      if (!(dma_req && !dg && $urandom_range(9) != 0))
        set_dma($urandom_range(99) < 60, $urandom_range(1),
                32'h1000 + ($urandom_range(15) << 2) + (($urandom_range(7) == 0) ? $urandom_range(3, 1) : 0),
                $urandom);
      if (i % 500 == 0)
        $display("txn random %0d cpu=%0b/%0b/%h dma=%0b/%0b/%h", i, cpu_req, cpu_we, cpu_addr,
                 dma_req, dma_we, dma_addr);
    end
    step();
    set_cpu(0, 0, 0, 0); set_dma(0, 0, 0, 0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the processor load/store path (CPU port) and a DMA/loader port.
- Arbitration uses fixed CPU priority plus a starvation counter, so the DMA port is guaranteed progress while the CPU keeps requesting.
- Read responses are routed back to the winning requester one cycle after the grant.
- Sits between the processor datapath and the data memory instance.

Parameters:
- AW, 32, byte-address width on both requester ports.
- DW, 32, data width.
- MEM_AW, 10, word-address width of the memory (mem_addr = addr[MEM_AW+1:2]).
- STARVE_LIMIT, 4, consecutive contested CPU wins after which DMA is granted; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held with its fields until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  byte address.
- cpu_wdata  in  DW  write data.
- cpu_gnt  out  1  combinational grant, same cycle as accepted request.
- cpu_rvalid  out  1  read data valid, registered.
- cpu_rdata  out  DW  read data.
- cpu_err  out  1  misaligned-access pulse, registered.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata, dma_err: same widths and meaning for the DMA port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  synchronous read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (rst=0, async):
  - cpu_rvalid, dma_rvalid, cpu_err, dma_err = 0.
  - streak counter = 0; rsp_owner = NONE.
  - rdata outputs = 0.
  - Any in-flight read response is discarded; no rvalid follows reset release.
- Grant, cycle N, combinational:
  - Only cpu_req: cpu_gnt=1.
  - Only dma_req: dma_gnt=1.
  - Both: CPU wins unless streak == STARVE_LIMIT, then DMA wins.
  - At most one gnt high per cycle; no req means no gnt.
- Memory drive, cycle N:
  - mem_en = cpu_gnt | dma_gnt.
  - mem_addr, mem_wdata taken from the winner.
  - mem_we = winner_we & aligned.
  - Misaligned (addr[1:0] != 0): mem_en still 1, write suppressed; read data is don't-care.
- Streak counter (4 bits):
  - Both requesting and CPU wins: +1.
  - DMA wins or dma_req=0: cleared to 0.
  - Never exceeds STARVE_LIMIT.
- Response FSM, states NONE / RSP_CPU / RSP_DMA:
  - On a granted read, next state = RSP_<winner>.
  - Write or no grant: next state = NONE.
  - In cycle N+1, RSP_x drives x_rvalid=1, x_rdata=mem_rdata.
  - x_rdata holds its last value when rvalid=0.
- Error:
  - x_err=1 in N+1 for a misaligned granted access.
  - A misaligned read also pulses x_rvalid with rdata = 0.
- Throughput: one access per cycle; back-to-back grants allowed; read latency 1.
- A requester dropping req before gnt is legal; nothing is issued for it.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds outputs stat_cpu_gnt[31:0], stat_dma_gnt[31:0], stat_conflict[31:0].
  - Saturating counters of CPU grants, DMA grants, and cycles with both req high.
  - Reset to 0.
- Undefined: ports and counters absent; arbitration behaviour identical.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - Owner encoding constants OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_DMA=2'd2.
  - Default widths.
- One natural sub-module: dmem_arb_sat_cnt, a parameterised saturating counter, instanced three times only under DMEM_ARB_STATS_EN.

Test Plan:
- Reset, then CPU read 0x1000 with mem preloaded 0x1000=5 -> cpu_gnt same cycle, mem_addr=0x400, cpu_rvalid=1, cpu_rdata=5 next cycle.
- Both ports request continuously, STARVE_LIMIT=4 -> grant pattern C,C,C,C,D repeating; streak never exceeds 4.
- CPU write 0x1004=0xAB, then DMA read 0x1004 -> dma_rdata=0xAB, cpu_rvalid stays 0.
- DMA write to misaligned 0x1006 -> mem_we=0, dma_err pulse 1 cycle later, memory unchanged.
- Assert rst=0 in the cycle after a granted CPU read -> cpu_rvalid never asserts; next request after release is served normally.
- With DMEM_ARB_STATS_EN, 10 contested cycles at STARVE_LIMIT=4 -> stat_cpu_gnt=8, stat_dma_gnt=2, stat_conflict=10.
